// File: rtl/wb_bus_cycle_ctrl.sv
// Wishbone slave turning one cyc/stb transfer into a timed chip-select + RDN/WRN strobe sequence; ack after WS+3 cycles.
// Optional macro IO_READY_EN: IORDY stretches I/O strobes up to TIMEOUT extra cycles, then wb_err_o pulses instead of ack.
module wb_bus_cycle_ctrl #(
  parameter int ADR_W    = 16,
  parameter int MEM_WS   = 1,
  parameter int IO_WS    = 3,
  parameter int IO0_BASE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic             wb_tga_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [15:0]      wb_dat_i,
  output logic [15:0]      wb_dat_o,
  output logic             wb_ack_o,
`ifdef IO_READY_EN
  input  logic             IORDY,
  output logic             wb_err_o,
`endif
  output logic             tga_o,
  output logic [ADR_W-1:0] MEMA,
  output logic [15:0]      MEMDATO,
  output logic             MEMCS_N,
  output logic             IOCS0_N,
  output logic             RDN,
  output logic             WRN,
  input  logic [15:0]      DATI
);

  localparam int WS_MAX = (MEM_WS > IO_WS) ? MEM_WS : IO_WS;
  localparam int CNT_W  = (WS_MAX < 1) ? 1 : $clog2(WS_MAX + 1);

  if (TIMEOUT < 1 || MEM_WS < 0 || IO_WS < 0 || ADR_W < 5) begin : g_bad_param
    $error("wb_bus_cycle_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               we_q, we_nxt;
  logic               ack_nxt, tga_nxt, memcs_nxt, iocs_nxt, rdn_nxt, wrn_nxt;
  logic [15:0]        dat_nxt, dato_nxt;
  logic [ADR_W-1:0]   adr_nxt;
  logic               io0_hit;
  logic               finish;

`ifdef IO_READY_EN
  localparam int EXT_W = $clog2(TIMEOUT + 1);
  logic [EXT_W-1:0]   ext, ext_nxt;
  logic               err_nxt;
`endif

  assign io0_hit = (wb_adr_i[ADR_W-1:4] == (ADR_W-4)'(IO0_BASE));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = we_q;
    ack_nxt   = 1'b0;
    dat_nxt   = wb_dat_o;
    tga_nxt   = tga_o;
    adr_nxt   = MEMA;
    dato_nxt  = MEMDATO;
    memcs_nxt = MEMCS_N;
    iocs_nxt  = IOCS0_N;
    rdn_nxt   = 1'b1;
    wrn_nxt   = 1'b1;
    finish    = 1'b0;
`ifdef IO_READY_EN
    ext_nxt   = ext;
    err_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        memcs_nxt = 1'b1;
        iocs_nxt  = 1'b1;
        if (wb_cyc_i && wb_stb_i) begin
          adr_nxt   = wb_adr_i;
          dato_nxt  = wb_dat_i;
          tga_nxt   = wb_tga_i;
          we_nxt    = wb_we_i;
          memcs_nxt = wb_tga_i;
          iocs_nxt  = !(wb_tga_i && io0_hit);
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (!wb_cyc_i) begin
          memcs_nxt = 1'b1;
          iocs_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = tga_o ? CNT_W'(IO_WS) : CNT_W'(MEM_WS);
          rdn_nxt   = we_q;
          wrn_nxt   = !we_q;
          state_nxt = STROBE;
`ifdef IO_READY_EN
          ext_nxt   = '0;
`endif
        end
      end
      STROBE: begin
        if (!wb_cyc_i) begin
          memcs_nxt = 1'b1;
          iocs_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
          rdn_nxt = we_q;
          wrn_nxt = !we_q;
        end else begin
          finish = 1'b1;
`ifdef IO_READY_EN
          // I/O devices may stretch the strobe; timeout ends the cycle with an error
          if (tga_o && !IORDY) begin
            finish = 1'b0;
            if (ext == EXT_W'(TIMEOUT)) begin
              err_nxt   = 1'b1;
              state_nxt = ACK;
            end else begin
              ext_nxt = ext + EXT_W'(1);
              rdn_nxt = we_q;
              wrn_nxt = !we_q;
            end
          end
`endif
          if (finish) begin
            ack_nxt   = 1'b1;
            state_nxt = ACK;
            if (!we_q) dat_nxt = DATI;
          end
        end
      end
      ACK: begin
        memcs_nxt = 1'b1;
        iocs_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      tga_o    <= 1'b0;
      MEMA     <= '0;
      MEMDATO  <= '0;
      MEMCS_N  <= 1'b1;
      IOCS0_N  <= 1'b1;
      RDN      <= 1'b1;
      WRN      <= 1'b1;
`ifdef IO_READY_EN
      ext      <= '0;
      wb_err_o <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      we_q     <= we_nxt;
      wb_ack_o <= ack_nxt;
      wb_dat_o <= dat_nxt;
      tga_o    <= tga_nxt;
      MEMA     <= adr_nxt;
      MEMDATO  <= dato_nxt;
      MEMCS_N  <= memcs_nxt;
      IOCS0_N  <= iocs_nxt;
      RDN      <= rdn_nxt;
      WRN      <= wrn_nxt;
`ifdef IO_READY_EN
      ext      <= ext_nxt;
      wb_err_o <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_wb_bus_cycle_ctrl.sv
// Directed bench for wb_bus_cycle_ctrl: per-cycle strobe/select/ack masks against hand-derived waveforms.
// Bit m of each mask = signal active in cycle k+m, where edge k accepts the request.
module tb_wb_bus_cycle_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i  = 1'b0;
  logic        wb_tga_i = 1'b0;
  logic [15:0] wb_adr_i = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;
  logic        tga_o;
  logic [15:0] MEMA;
  logic [15:0] MEMDATO;
  logic        MEMCS_N, IOCS0_N, RDN, WRN;
  logic [15:0] DATI;
  logic [15:0] dati_src = '0;
`ifdef IO_READY_EN
  logic        IORDY = 1'b1;
  logic        wb_err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_memcs, m_iocs, m_rdn, m_wrn, m_ack, m_err;

  // Read mux model: drives data only while a select and RDN are both active
  assign DATI = (RDN || (MEMCS_N && IOCS0_N)) ? 16'h0000 : dati_src;

  always #5 wb_clk_i = !wb_clk_i;

  wb_bus_cycle_ctrl #(.ADR_W(16), .MEM_WS(1), .IO_WS(3), .IO0_BASE(0), .TIMEOUT(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_tga_i(wb_tga_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
`ifdef IO_READY_EN
    .IORDY(IORDY), .wb_err_o(wb_err_o),
`endif
    .tga_o(tga_o), .MEMA(MEMA), .MEMDATO(MEMDATO), .MEMCS_N(MEMCS_N), .IOCS0_N(IOCS0_N),
    .RDN(RDN), .WRN(WRN), .DATI(DATI)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Issue one request at edge k and record 10 cycles of activity.
  task automatic run_xfer(input logic we, input logic tga, input logic [15:0] adr,
                          input logic [15:0] dat, input logic [15:0] src,
                          input bit hold_stb, input int rise_m);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_tga_i = tga;
    wb_adr_i = adr; wb_dat_i = dat; dati_src = src;
`ifdef IO_READY_EN
    IORDY = (rise_m == 0);
`endif
    m_memcs = '0; m_iocs = '0; m_rdn = '0; m_wrn = '0; m_ack = '0; m_err = '0;
    tick();
    for (int m = 1; m <= 10; m++) begin
      m_memcs[m] = !MEMCS_N;
      m_iocs[m]  = !IOCS0_N;
      m_rdn[m]   = !RDN;
      m_wrn[m]   = !WRN;
      m_ack[m]   = wb_ack_o;
`ifdef IO_READY_EN
      m_err[m]   = wb_err_o;
      IORDY      = (m >= rise_m);
`endif
      if (m == 1 && !hold_stb) wb_stb_i = 1'b0;
      if (m == 10) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      tick();
    end
`ifdef IO_READY_EN
    IORDY = 1'b1;
`endif
  endtask

  initial begin
    repeat (2) @(posedge wb_clk_i);
    #1;
    check("rst_ack", wb_ack_o, 0);
    check("rst_dat", wb_dat_o, 16'h0000);
    check("rst_memcs", MEMCS_N, 1);
    check("rst_iocs", IOCS0_N, 1);
    check("rst_rdn", RDN, 1);
    check("rst_wrn", WRN, 1);
    check("rst_mema", MEMA, 16'h0000);
    check("rst_tga", tga_o, 0);
    #3 wb_rst_i = 1'b0;
    tick();

    // Memory read, 1 wait state
    run_xfer(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 0);
    check("mrd_memcs", m_memcs, 16'h001E);
    check("mrd_iocs", m_iocs, 16'h0000);
    check("mrd_rdn", m_rdn, 16'h000C);
    check("mrd_wrn", m_wrn, 16'h0000);
    check("mrd_ack", m_ack, 16'h0010);
    check("mrd_dat", wb_dat_o, 16'hBEEF);
    check("mrd_mema", MEMA, 16'h0010);

    // I/O write to IO0, 3 wait states
    run_xfer(1'b1, 1'b1, 16'h0002, 16'h1234, 16'h7777, 1'b0, 0);
    check("iowr_iocs", m_iocs, 16'h007E);
    check("iowr_memcs", m_memcs, 16'h0000);
    check("iowr_wrn", m_wrn, 16'h003C);
    check("iowr_rdn", m_rdn, 16'h0000);
    check("iowr_ack", m_ack, 16'h0040);
    check("iowr_datout", MEMDATO, 16'h1234);
    check("iowr_dat_hold", wb_dat_o, 16'hBEEF);
    check("iowr_tga", tga_o, 1);

    // Unmapped I/O read
    run_xfer(1'b0, 1'b1, 16'hFFF0, 16'h0000, 16'hDEAD, 1'b0, 0);
    check("unm_cs", m_memcs | m_iocs, 16'h0000);
    check("unm_rdn", m_rdn, 16'h003C);
    check("unm_ack", m_ack, 16'h0040);
    check("unm_dat", wb_dat_o, 16'h0000);

    // Abort a memory read during STROBE
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_tga_i = 1'b0;
    wb_adr_i = 16'h0020; dati_src = 16'h5A5A;
    tick();
    wb_stb_i = 1'b0;
    tick();
    check("abt_rdn_active", RDN, 0);
    wb_cyc_i = 1'b0;
    tick();
    check("abt_rdn", RDN, 1);
    check("abt_memcs", MEMCS_N, 1);
    m_ack = '0;
    for (int i = 0; i < 4; i++) begin
      m_ack[i] = wb_ack_o;
      tick();
    end
    check("abt_noack", m_ack, 16'h0000);
    check("abt_dat", wb_dat_o, 16'h0000);
    run_xfer(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0F0F, 1'b0, 0);
    check("post_abt_ack", m_ack, 16'h0010);
    check("post_abt_dat", wb_dat_o, 16'h0F0F);

    // Back-to-back with stb held high: second accept only from IDLE
    run_xfer(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hA55A, 1'b1, 0);
    check("b2b_ack", m_ack, 16'h0210);
    check("b2b_memcs", m_memcs, 16'h03DE);
    check("b2b_dat", wb_dat_o, 16'hA55A);

    // Asynchronous reset mid-STROBE
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_tga_i = 1'b0;
    wb_adr_i = 16'h0050; dati_src = 16'h1111;
    tick();
    wb_stb_i = 1'b0;
    tick();
    check("rst2_rdn_active", RDN, 0);
    #2 wb_rst_i = 1'b1;
    #1;
    check("rst2_rdn", RDN, 1);
    check("rst2_memcs", MEMCS_N, 1);
    check("rst2_ack", wb_ack_o, 0);
    check("rst2_dat", wb_dat_o, 16'h0000);
    wb_cyc_i = 1'b0;
    #2 wb_rst_i = 1'b0;
    tick();

`ifdef IO_READY_EN
    // IORDY never rises: error pulse after TIMEOUT extra cycles
    run_xfer(1'b0, 1'b1, 16'h0003, 16'h0000, 16'h9999, 1'b0, 99);
    check("tmo_ack", m_ack, 16'h0000);
    check("tmo_err", m_err, 16'h0400);
    check("tmo_dat", wb_dat_o, 16'h0000);
    // IORDY rises after 2 extra cycles
    run_xfer(1'b0, 1'b1, 16'h0003, 16'h0000, 16'hC3C3, 1'b0, 7);
    check("rdy_ack", m_ack, 16'h0100);
    check("rdy_err", m_err, 16'h0000);
    check("rdy_dat", wb_dat_o, 16'hC3C3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
